// File: rtl/op_sched.sv
// ============================================================================
// op_sched : round-robin scheduler that sequences (row, col) element indices
//            through the outer-product engine. Revision 1.0
// ============================================================================
`default_nettype none

module op_sched #(
    parameter int ROWS  = 15,
    parameter int COLS  = 16,
    parameter int NREQ  = 2,
    parameter int IDX_W = 5,
    parameter int ID_W  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req,
    input  logic             abort,
    output logic [NREQ-1:0]  gnt,
    output logic             busy,
    output logic [ID_W-1:0]  owner,
    output logic [IDX_W-1:0] row_idx,
    output logic [IDX_W-1:0] col_idx,
    output logic             elem_valid,
    input  logic             elem_ready,
    output logic             last,
    output logic             done,
    output logic [ID_W-1:0]  done_id
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam bit c_LAST_AT_START = (ROWS == 1) && (COLS == 1);

    state_t           r_state;
    logic [ID_W-1:0]  r_ptr;
    logic [ID_W-1:0]  w_winner;
    logic             w_found;
    logic [NREQ-1:0]  w_rot;
    logic             w_col_end;
    logic [IDX_W-1:0] w_next_col;
    logic [IDX_W-1:0] w_next_row;
    logic             w_next_last;

    // Walk downward so the candidate closest after the pointer is written last and wins.
    always_comb begin
        w_winner = '0;
        w_rot    = '0;
        w_found  = |req;
        for (int k = NREQ; k >= 1; k--) begin
            w_rot = req >> ((int'(r_ptr) + k) % NREQ);
            if (w_rot[0]) begin
                w_winner = ID_W'((int'(r_ptr) + k) % NREQ);
            end
        end
    end

    always_comb begin
        w_col_end   = (col_idx == IDX_W'(COLS - 1));
        w_next_col  = w_col_end ? '0 : col_idx + 1'b1;
        w_next_row  = w_col_end ? row_idx + 1'b1 : row_idx;
        w_next_last = (w_next_row == IDX_W'(ROWS - 1)) && (w_next_col == IDX_W'(COLS - 1));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_ptr      <= ID_W'(NREQ - 1);
            gnt        <= '0;
            busy       <= 1'b0;
            owner      <= '0;
            row_idx    <= '0;
            col_idx    <= '0;
            elem_valid <= 1'b0;
            last       <= 1'b0;
            done       <= 1'b0;
            done_id    <= '0;
        end else begin
            gnt  <= '0;
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_state    <= S_RUN;
                        gnt        <= NREQ'(1) << w_winner;
                        owner      <= w_winner;
                        r_ptr      <= w_winner;
                        busy       <= 1'b1;
                        elem_valid <= 1'b1;
                        row_idx    <= '0;
                        col_idx    <= '0;
                        last       <= c_LAST_AT_START;
                    end
                end
                S_RUN: begin
                    // Abort takes precedence even over the final handshake.
                    if (abort) begin
                        r_state    <= S_IDLE;
                        busy       <= 1'b0;
                        elem_valid <= 1'b0;
                        last       <= 1'b0;
                        row_idx    <= '0;
                        col_idx    <= '0;
                    end else if (elem_ready) begin
                        if (last) begin
                            r_state    <= S_DONE;
                            elem_valid <= 1'b0;
                            last       <= 1'b0;
                            done       <= 1'b1;
                            done_id    <= owner;
                            row_idx    <= '0;
                            col_idx    <= '0;
                        end else begin
                            row_idx <= w_next_row;
                            col_idx <= w_next_col;
                            last    <= w_next_last;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state    <= S_IDLE;
                    busy       <= 1'b0;
                    elem_valid <= 1'b0;
                    last       <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
